// File: rtl/touch_scan_ctrl.sv
// Touch-screen ADC scan sequencer: debounces the pen interrupt, then converts
// NUM_CH channels over an external SPI engine and idles before re-arming.
module touch_scan_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 12,
    parameter int DEBOUNCE    = 4,
    parameter int WAIT_CYCLES = 50000,
    parameter int TIMEOUT     = 1024
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              ADC_PENIRQ_n,
    input  logic              SPI_DONE,
    input  logic [DATA_W-1:0] SPI_RDATA,
    output logic              ADC_CS,
    output logic              SPI_START,
    output logic [7:0]        SPI_CMD,
    output logic              SAMPLE_VALID,
    output logic [1:0]        SAMPLE_CH,
    output logic [DATA_W-1:0] SAMPLE_DATA,
    output logic              SCAN_DONE,
    output logic              ERR,
    output logic              BUSY
);

    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int WT_W  = $clog2(WAIT_CYCLES + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(WAIT_CYCLES - 1);
    localparam logic [1:0]       LAST_CH  = 2'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        XFER,
        STORE,
        DONE,
        WAIT
    } state_t;

    state_t            state;
    logic [1:0]        ch;
    logic [DEB_W-1:0]  deb_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [WT_W-1:0]   wait_cnt;
    logic              pen_meta;
    logic              pen_sync;
    logic              pen_down;

    function automatic logic [7:0] cmd_for(input logic [1:0] c);
        case (c)
            2'd0:    cmd_for = 8'h90;
            2'd1:    cmd_for = 8'hD0;
            2'd2:    cmd_for = 8'hB0;
            default: cmd_for = 8'hC0;
        endcase
    endfunction

    // Synchroniser resets to pen-up so a reset never looks like a touch.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pen_meta <= 1'b1;
            pen_sync <= 1'b1;
        end else begin
            pen_meta <= ADC_PENIRQ_n;
            pen_sync <= pen_meta;
        end
    end

    assign pen_down = ~pen_sync;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state        <= IDLE;
            ch           <= 2'd0;
            deb_cnt      <= '0;
            to_cnt       <= '0;
            wait_cnt     <= '0;
            ADC_CS       <= 1'b0;
            SPI_START    <= 1'b0;
            SPI_CMD      <= 8'h00;
            SAMPLE_VALID <= 1'b0;
            SAMPLE_CH    <= 2'd0;
            SAMPLE_DATA  <= '0;
            SCAN_DONE    <= 1'b0;
            ERR          <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            SPI_START    <= 1'b0;
            SAMPLE_VALID <= 1'b0;
            SCAN_DONE    <= 1'b0;
            ERR          <= 1'b0;
            case (state)
                IDLE: begin
                    if (pen_down) begin
                        state   <= ARM;
                        deb_cnt <= '0;
                        BUSY    <= 1'b1;
                    end
                end
                ARM: begin
                    if (!pen_down) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= START;
                        ch        <= 2'd0;
                        to_cnt    <= '0;
                        SPI_START <= 1'b1;
                        ADC_CS    <= 1'b1;
                        SPI_CMD   <= cmd_for(2'd0);
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                START: begin
                    state <= XFER;
                end
                XFER: begin
                    // A result arriving on the final allowed cycle beats the timeout.
                    if (SPI_DONE) begin
                        state        <= STORE;
                        SAMPLE_VALID <= 1'b1;
                        SAMPLE_DATA  <= SPI_RDATA;
                        SAMPLE_CH    <= ch;
                    end else if (to_cnt == TO_LAST) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                        ERR      <= 1'b1;
                        ADC_CS   <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                STORE: begin
                    if (ch == LAST_CH) begin
                        state     <= DONE;
                        SCAN_DONE <= 1'b1;
                        ADC_CS    <= 1'b0;
                    end else begin
                        state     <= START;
                        ch        <= ch + 2'd1;
                        to_cnt    <= '0;
                        SPI_START <= 1'b1;
                        SPI_CMD   <= cmd_for(ch + 2'd1);
                    end
                end
                DONE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WT_LAST) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ADC_CS <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Bench for touch_scan_ctrl: plays pen and SPI engine, predicts each scan's
// commands, samples and pulse timing from cycle arithmetic.
module tb_touch_scan_ctrl;

    localparam int NUM_CH        = 4;
    localparam int DATA_W        = 12;
    localparam int DEBOUNCE      = 4;
    localparam int WAIT_CYCLES   = 20;
    localparam int TIMEOUT       = 16;
    localparam int PRESS_LATENCY = 3 + DEBOUNCE;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              ADC_PENIRQ_n;
    logic              SPI_DONE;
    logic [DATA_W-1:0] SPI_RDATA;
    logic              ADC_CS;
    logic              SPI_START;
    logic [7:0]        SPI_CMD;
    logic              SAMPLE_VALID;
    logic [1:0]        SAMPLE_CH;
    logic [DATA_W-1:0] SAMPLE_DATA;
    logic              SCAN_DONE;
    logic              ERR;
    logic              BUSY;

    int n_checks = 0;
    int n_fail = 0;
    int exp_starts = 0, exp_samples = 0, exp_scans = 0, exp_errs = 0;
    int mon_starts = 0, mon_samples = 0, mon_scans = 0, mon_errs = 0;

    logic [DATA_W-1:0] last_data = '0;
    int                dir_delay [NUM_CH];
    logic [DATA_W-1:0] dir_data  [NUM_CH];
    bit                use_dir = 1'b0;

    touch_scan_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE(DEBOUNCE),
        .WAIT_CYCLES(WAIT_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .ADC_PENIRQ_n(ADC_PENIRQ_n),
        .SPI_DONE(SPI_DONE), .SPI_RDATA(SPI_RDATA), .ADC_CS(ADC_CS),
        .SPI_START(SPI_START), .SPI_CMD(SPI_CMD), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_CH(SAMPLE_CH), .SAMPLE_DATA(SAMPLE_DATA), .SCAN_DONE(SCAN_DONE),
        .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (SPI_START === 1'b1)    mon_starts++;
        if (SAMPLE_VALID === 1'b1) mon_samples++;
        if (SCAN_DONE === 1'b1)    mon_scans++;
        if (ERR === 1'b1)          mon_errs++;
    end

    function automatic logic [7:0] model_cmd(input int c);
        logic [7:0] table_cmd [4] = '{8'h90, 8'hD0, 8'hB0, 8'hC0};
        return table_cmd[c];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cs"}, ADC_CS, 0);
        check_output({tag, "_start"}, SPI_START, 0);
        check_output({tag, "_cmd"}, SPI_CMD, 0);
        check_output({tag, "_valid"}, SAMPLE_VALID, 0);
        check_output({tag, "_ch"}, SAMPLE_CH, 0);
        check_output({tag, "_data"}, SAMPLE_DATA, 0);
        check_output({tag, "_scan_done"}, SCAN_DONE, 0);
        check_output({tag, "_err"}, ERR, 0);
        check_output({tag, "_busy"}, BUSY, 0);
    endtask

    task automatic wait_start(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (SPI_START !== 1'b1 && cyc < 100);
        check_output(tag, cyc, PRESS_LATENCY);
    endtask

    task automatic check_start(input int c);
        exp_starts++;
        check_output("spi_start", SPI_START, 1);
        check_output($sformatf("cmd_ch%0d", c), SPI_CMD, model_cmd(c));
        check_output("cs_in_start", ADC_CS, 1);
        check_output("busy_in_start", BUSY, 1);
    endtask

    // Enters at the START cycle of channel c, leaves at the STORE cycle.
    task automatic serve_ok(input int c, input int n, input logic [DATA_W-1:0] d);
        check_start(c);
        repeat (n) @(negedge CLK);
        check_output("cs_in_xfer", ADC_CS, 1);
        check_output("no_early_sample", SAMPLE_VALID, 0);
        SPI_DONE  = 1'b1;
        SPI_RDATA = d;
        @(negedge CLK);
        SPI_DONE  = 1'b0;
        SPI_RDATA = DATA_W'($urandom);
        exp_samples++;
        check_output("sample_valid", SAMPLE_VALID, 1);
        check_output($sformatf("sample_ch%0d", c), SAMPLE_CH, c);
        check_output($sformatf("sample_data_ch%0d", c), SAMPLE_DATA, d);
        last_data = d;
    endtask

    function automatic int pick_delay(input int c);
        if (use_dir) return dir_delay[c];
        if ($urandom_range(0, 3) == 0) return TIMEOUT;
        return $urandom_range(1, TIMEOUT);
    endfunction

    // Enters at the START cycle of channel 0; with the pen held it returns at
    // the START cycle of the following scan.
    task automatic apply_stimulus(input int to_ch, input bit release_pen);
        bit aborted;
        int n;
        logic [DATA_W-1:0] d;
        aborted = 1'b0;
        for (int c = 0; c < NUM_CH && !aborted; c++) begin
            if (c == 0 && release_pen) ADC_PENIRQ_n = 1'b1;
            if (c == to_ch) begin
                check_start(c);
                exp_errs++;
                repeat (TIMEOUT) @(negedge CLK);
                check_output("err_not_early", ERR, 0);
                check_output("cs_last_xfer", ADC_CS, 1);
                @(negedge CLK);
                check_output("err_pulse", ERR, 1);
                check_output("cs_after_timeout", ADC_CS, 0);
                check_output("busy_after_timeout", BUSY, 1);
                check_output("no_sample_on_timeout", SAMPLE_VALID, 0);
                SPI_DONE  = 1'b1;
                SPI_RDATA = DATA_W'($urandom);
                @(negedge CLK);
                SPI_DONE = 1'b0;
                check_output("err_one_cycle", ERR, 0);
                check_output("late_done_ignored", SAMPLE_VALID, 0);
                check_output("no_scan_done_on_err", SCAN_DONE, 0);
                check_output("data_hold_after_err", SAMPLE_DATA, last_data);
                repeat (WAIT_CYCLES - 2) @(negedge CLK);
                aborted = 1'b1;
            end else begin
                n = pick_delay(c);
                d = use_dir ? dir_data[c] : DATA_W'($urandom);
                serve_ok(c, n, d);
                @(negedge CLK);
                check_output("sample_one_cycle", SAMPLE_VALID, 0);
                check_output("sample_hold", SAMPLE_DATA, last_data);
                if (c == NUM_CH - 1) begin
                    exp_scans++;
                    check_output("scan_done", SCAN_DONE, 1);
                    check_output("cs_low_done", ADC_CS, 0);
                    @(negedge CLK);
                    check_output("scan_done_one_cycle", SCAN_DONE, 0);
                    SPI_DONE = 1'b1;
                    @(negedge CLK);
                    SPI_DONE = 1'b0;
                    check_output("wait_done_ignored", SAMPLE_VALID, 0);
                    repeat (WAIT_CYCLES - 2) @(negedge CLK);
                end
            end
        end
        check_output("busy_last_wait", BUSY, 1);
        @(negedge CLK);
        check_output("idle_after_wait", BUSY, 0);
        check_output("cs_idle", ADC_CS, 0);
        if (!release_pen) begin
            repeat (DEBOUNCE + 1) @(negedge CLK);
        end else begin
            repeat (10) @(negedge CLK);
            check_output("stays_idle_released", BUSY, 0);
        end
    endtask

    initial begin
        int k;
        bit rel;
        int to_ch;
        RST_n        = 1'b0;
        ADC_PENIRQ_n = 1'b1;
        SPI_DONE     = 1'b0;
        SPI_RDATA    = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_n = 1'b1;
        @(negedge CLK);

        SPI_DONE  = 1'b1;
        SPI_RDATA = 12'hABC;
        @(negedge CLK);
        SPI_DONE = 1'b0;
        check_output("idle_done_no_sample", SAMPLE_VALID, 0);
        check_output("idle_done_no_data", SAMPLE_DATA, 0);
        check_output("idle_busy", BUSY, 0);

        k = $urandom_range(1, DEBOUNCE);
        ADC_PENIRQ_n = 1'b0;
        repeat (k) @(negedge CLK);
        ADC_PENIRQ_n = 1'b1;
        repeat (12) @(negedge CLK);
        check_output("short_press_idle", BUSY, 0);
        check_output("short_press_no_start", mon_starts, exp_starts);

        ADC_PENIRQ_n = 1'b0;
        wait_start("press_latency");
        use_dir  = 1'b1;
        dir_delay = '{10, 10, 10, 10};
        dir_data  = '{12'h123, 12'h456, 12'h5A5, 12'hA5A};
        apply_stimulus(-1, 1'b0);
        dir_delay = '{1, TIMEOUT, 7, 3};
        for (int i = 0; i < NUM_CH; i++) dir_data[i] = DATA_W'($urandom);
        apply_stimulus(-1, 1'b0);
        use_dir = 1'b0;

        for (int i = 0; i < 6; i++) begin
            to_ch = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_CH - 1)) : -1;
            rel   = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            apply_stimulus(to_ch, rel);
            if (rel && i < 5) begin
                ADC_PENIRQ_n = 1'b0;
                wait_start("repress_latency");
            end
        end

        ADC_PENIRQ_n = 1'b0;
        wait_start("press_before_timeout");
        apply_stimulus(1, 1'b0);

        serve_ok(0, $urandom_range(1, TIMEOUT), DATA_W'($urandom));
        @(negedge CLK);
        check_start(1);
        repeat (3) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_xfer");
        last_data = '0;
        @(negedge CLK);
        RST_n = 1'b1;
        wait_start("restart_after_reset");
        apply_stimulus(-1, 1'b1);

        repeat (5) @(negedge CLK);
        check_output("total_starts", mon_starts, exp_starts);
        check_output("total_samples", mon_samples, exp_samples);
        check_output("total_scans", mon_scans, exp_scans);
        check_output("total_errs", mon_errs, exp_errs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
